// File: rtl/gpio_pad_arbiter.sv
// rtl/gpio_pad_arbiter.sv - round-robin MCU/fabric arbiter for one shared GPIO pad with debounced button
// GPIO_ARB_BTN_LOCK_EN: each debounced press toggles fab_lock, which locks the MCU out of the pad.
`timescale 1ns/1ps
module gpio_pad_arbiter #(
  parameter int MAX_GRANT       = 1024,
  parameter int TA_CYCLES       = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk25,
  input  logic fpga_rst_n,
  input  logic mcu_req,
  input  logic mcu_out,
  input  logic mcu_oe_n,
  input  logic fab_req,
  input  logic fab_out,
  input  logic pad_in,
  input  logic button_n,
  output logic pad_out,
  output logic pad_oe_n,
  output logic mcu_in,
  output logic mcu_gnt,
  output logic fab_gnt,
  output logic btn_press,
  output logic fab_lock
);

  localparam logic [15:0] GRANT_LAST = 16'(MAX_GRANT - 1);
  localparam int TA_W = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;
  localparam logic [TA_W-1:0] TA_LAST = TA_W'(TA_CYCLES - 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GNT_MCU, GNT_FAB, TA} state_t;

  state_t          state, state_nxt;
  logic            last_fab, last_fab_nxt;
  logic [15:0]     grant_cnt;
  logic [TA_W-1:0] ta_cnt;
  logic            mcu_req_eff;

  logic [1:0]      btn_sync;
  logic            btn_level;
  logic [DB_W-1:0] db_cnt;

  assign mcu_in      = pad_in;
  assign mcu_req_eff = mcu_req & ~fab_lock;

  always_comb begin
    state_nxt    = state;
    last_fab_nxt = last_fab;
    pad_out      = 1'b0;
    pad_oe_n     = 1'b1;
    mcu_gnt      = 1'b0;
    fab_gnt      = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not own the pad last time wins.
        if (mcu_req_eff && (!fab_req || last_fab)) begin
          state_nxt    = GNT_MCU;
          last_fab_nxt = 1'b0;
        end else if (fab_req) begin
          state_nxt    = GNT_FAB;
          last_fab_nxt = 1'b1;
        end
      end
      GNT_MCU: begin
        pad_out  = mcu_out;
        pad_oe_n = mcu_oe_n;
        mcu_gnt  = 1'b1;
        if (!mcu_req || fab_lock || (grant_cnt == GRANT_LAST && fab_req))
          state_nxt = TA;
      end
      GNT_FAB: begin
        pad_out  = fab_out;
        pad_oe_n = 1'b0;
        fab_gnt  = 1'b1;
        if (!fab_req || (grant_cnt == GRANT_LAST && mcu_req_eff))
          state_nxt = TA;
      end
      TA: begin
        if (ta_cnt == TA_LAST)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state     <= IDLE;
      last_fab  <= 1'b1;
      grant_cnt <= 16'd0;
      ta_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      last_fab <= last_fab_nxt;
      if (state == IDLE)
        grant_cnt <= 16'd0;
      else if ((state == GNT_MCU || state == GNT_FAB) && grant_cnt != GRANT_LAST)
        grant_cnt <= grant_cnt + 16'd1;
      ta_cnt <= (state == TA) ? ta_cnt + TA_W'(1) : '0;
    end
  end

  // Debounce: the accepted level moves only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      btn_sync  <= 2'b11;
      btn_level <= 1'b1;
      db_cnt    <= '0;
      btn_press <= 1'b0;
    end else begin
      btn_sync  <= {btn_sync[0], button_n};
      btn_press <= 1'b0;
      if (btn_sync[1] != btn_level) begin
        if (db_cnt == DB_LAST) begin
          btn_level <= btn_sync[1];
          db_cnt    <= '0;
          btn_press <= btn_level;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

`ifdef GPIO_ARB_BTN_LOCK_EN
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n)
      fab_lock <= 1'b0;
    else if (btn_press)
      fab_lock <= ~fab_lock;
  end
`else
  assign fab_lock = 1'b0;
`endif

endmodule
